// File: rtl/acq_sequencer_pkg.sv
// acq_sequencer_pkg: shared states and constants for the acquisition sequencer
package acq_sequencer_pkg;
  localparam int DW_DEF = 14;
  localparam int CW_DEF = 16;
  localparam int CMD_START = 0;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, DONE} state_t;
endpackage

// File: rtl/acq_trig_detect.sv
// acq_trig_detect: signed rising-crossing trigger on the ADC sample stream
module acq_trig_detect #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          en_i,
  input  logic          data_valid_i,
  input  logic [DW-1:0] trig_data_i,
  input  logic [DW-1:0] level_i,
  output logic          trig_hit_o
);
  logic signed [DW-1:0] prev_q;
  // previous sample; reloaded to the most negative value so the first sample can cross
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= {1'b1, {(DW-1){1'b0}}};
    else if (load_i) prev_q <= {1'b1, {(DW-1){1'b0}}};
    else if (data_valid_i) prev_q <= trig_data_i;
  end
  assign trig_hit_o = en_i & data_valid_i & (prev_q < $signed(level_i)) &
                      ($signed(trig_data_i) >= $signed(level_i));
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: arms on start, triggers on the sample stream and frames pulses into range bins
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] UR_nTotalPoins,
  input  logic [CW-1:0] UR_nRangeBins,
  input  logic [CW-1:0] UR_nPoints_RB,
  input  logic [CW-1:0] UR_nACC_Pulses,
  input  logic [CW-1:0] UR_TriggerLevel,
  input  logic [CW-1:0] UR_CMD,
  input  logic          abort_i,
  input  logic [DW-1:0] trig_data,
  input  logic          data_valid,
  output logic          CMD_Update_Disable,
  output logic          cap_valid,
  output logic          cap_first,
  output logic          rb_valid,
  output logic          rb_last,
  output logic [CW-1:0] rb_index,
  output logic          pulse_first,
  output logic          pulse_last,
  output logic          acq_done,
  output logic          cfg_err
);
  state_t state_q, state_d;
  logic cmd_q;
  logic [CW-1:0] n_tot_q, n_tot_d, n_rb_q, n_rb_d, n_pts_q, n_pts_d, n_acc_q, n_acc_d;
  logic [DW-1:0] lvl_q, lvl_d;
  logic [CW-1:0] samp_q, samp_d, pt_q, pt_d, rb_q, rb_d, pulse_q, pulse_d;
  logic [CW-1:0] idx, pt, rb, rb_index_d;
  logic [2*CW-1:0] rb_span;
  logic start, bad, kill, s_ev, last_s, in_rb, rb_end, more, act, reload, trig_hit;
  logic cfg_err_d, cap_valid_d, cap_first_d, rb_valid_d, rb_last_d;
  logic pulse_first_d, pulse_last_d, acq_done_d, cud_d;
  logic unused_bits;
  assign unused_bits = ^{UR_CMD[CW-1:CMD_START+1], UR_TriggerLevel[CW-1:DW]};
  assign rb_span = {{CW{1'b0}}, n_rb_q} * {{CW{1'b0}}, n_pts_q};
  acq_trig_detect #(.DW(DW)) u_trig (
    .clk          (clk),
    .rst          (rst),
    .load_i       ((state_q == ARM) | reload),
    .en_i         (state_q == WAIT_TRIG),
    .data_valid_i (data_valid),
    .trig_data_i  (trig_data),
    .level_i      (lvl_q),
    .trig_hit_o   (trig_hit)
  );
  // next state, counters and framing outputs for the sample presented this cycle
  always_comb begin
    start = UR_CMD[CMD_START] & ~cmd_q;
    bad = ~|UR_nTotalPoins | ~|UR_nRangeBins | ~|UR_nPoints_RB | ~|UR_nACC_Pulses;
    kill = abort_i & (state_q != IDLE);
    idx = (state_q == CAPTURE) ? samp_q : '0;
    pt = (state_q == CAPTURE) ? pt_q : '0;
    rb = (state_q == CAPTURE) ? rb_q : '0;
    s_ev = ((state_q == WAIT_TRIG) & trig_hit) | ((state_q == CAPTURE) & data_valid);
    last_s = idx == n_tot_q - CW'(1);
    in_rb = {{CW{1'b0}}, idx} < rb_span;
    rb_end = in_rb & (pt == n_pts_q - CW'(1));
    more = pulse_q != n_acc_q - CW'(1);
    act = ((state_q == WAIT_TRIG) | (state_q == CAPTURE)) & ~kill;
    state_d = state_q;
    n_tot_d = n_tot_q;
    n_rb_d = n_rb_q;
    n_pts_d = n_pts_q;
    n_acc_d = n_acc_q;
    lvl_d = lvl_q;
    samp_d = samp_q;
    pt_d = pt_q;
    rb_d = rb_q;
    pulse_d = pulse_q;
    cfg_err_d = cfg_err;
    reload = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cfg_err_d = bad;
        if (!bad) begin
          state_d = ARM;
          n_tot_d = UR_nTotalPoins;
          n_rb_d = UR_nRangeBins;
          n_pts_d = UR_nPoints_RB;
          n_acc_d = UR_nACC_Pulses;
          lvl_d = UR_TriggerLevel[DW-1:0];
        end
      end
      ARM: begin
        state_d = WAIT_TRIG;
        samp_d = '0;
        pt_d = '0;
        rb_d = '0;
        pulse_d = '0;
      end
      WAIT_TRIG, CAPTURE: if (s_ev) begin
        if (last_s && more) begin
          state_d = WAIT_TRIG;
          pulse_d = pulse_q + CW'(1);
          reload = 1'b1;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = CAPTURE;
          samp_d = idx + CW'(1);
          pt_d = rb_end ? '0 : pt + CW'(1);
          rb_d = rb_end ? rb + CW'(1) : rb;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
    cap_valid_d = s_ev & ~kill;
    cap_first_d = s_ev & ~kill & (idx == '0);
    rb_valid_d = s_ev & ~kill & in_rb;
    rb_last_d = s_ev & ~kill & rb_end;
    rb_index_d = kill ? '0 : s_ev ? rb : rb_index;
    pulse_first_d = act & (pulse_q == '0);
    pulse_last_d = act & ~more;
    acq_done_d = state_d == DONE;
    cud_d = state_d != IDLE;
  end
  // state, latched configuration, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= 1'b0;
      n_tot_q <= '0;
      n_rb_q <= '0;
      n_pts_q <= '0;
      n_acc_q <= '0;
      lvl_q <= '0;
      samp_q <= '0;
      pt_q <= '0;
      rb_q <= '0;
      pulse_q <= '0;
      cfg_err <= 1'b0;
      cap_valid <= 1'b0;
      cap_first <= 1'b0;
      rb_valid <= 1'b0;
      rb_last <= 1'b0;
      rb_index <= '0;
      pulse_first <= 1'b0;
      pulse_last <= 1'b0;
      acq_done <= 1'b0;
      CMD_Update_Disable <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= UR_CMD[CMD_START];
      n_tot_q <= n_tot_d;
      n_rb_q <= n_rb_d;
      n_pts_q <= n_pts_d;
      n_acc_q <= n_acc_d;
      lvl_q <= lvl_d;
      samp_q <= samp_d;
      pt_q <= pt_d;
      rb_q <= rb_d;
      pulse_q <= pulse_d;
      cfg_err <= cfg_err_d;
      cap_valid <= cap_valid_d;
      cap_first <= cap_first_d;
      rb_valid <= rb_valid_d;
      rb_last <= rb_last_d;
      rb_index <= rb_index_d;
      pulse_first <= pulse_first_d;
      pulse_last <= pulse_last_d;
      acq_done <= acq_done_d;
      CMD_Update_Disable <= cud_d;
    end
  end
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed stimulus against a behavioural model feeding a one-deep scoreboard
module tb_acq_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] UR_nTotalPoins = '0, UR_nRangeBins = '0, UR_nPoints_RB = '0;
  logic [15:0] UR_nACC_Pulses = '0, UR_TriggerLevel = '0, UR_CMD = '0;
  logic abort_i = 1'b0, data_valid = 1'b0;
  logic [13:0] trig_data = '0;
  logic CMD_Update_Disable, cap_valid, cap_first, rb_valid, rb_last;
  logic pulse_first, pulse_last, acq_done, cfg_err;
  logic [15:0] rb_index;

  always #5 clk = ~clk;

  acq_sequencer dut (
    .clk(clk), .rst(rst),
    .UR_nTotalPoins(UR_nTotalPoins), .UR_nRangeBins(UR_nRangeBins),
    .UR_nPoints_RB(UR_nPoints_RB), .UR_nACC_Pulses(UR_nACC_Pulses),
    .UR_TriggerLevel(UR_TriggerLevel), .UR_CMD(UR_CMD), .abort_i(abort_i),
    .trig_data(trig_data), .data_valid(data_valid),
    .CMD_Update_Disable(CMD_Update_Disable), .cap_valid(cap_valid), .cap_first(cap_first),
    .rb_valid(rb_valid), .rb_last(rb_last), .rb_index(rb_index),
    .pulse_first(pulse_first), .pulse_last(pulse_last), .acq_done(acq_done), .cfg_err(cfg_err)
  );

  typedef struct packed {logic [8:0] f; logic [15:0] ri;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, n_cv = 0, n_ad = 0, n_rl = 0;
  int m_st = 0, m_prev = 0, m_idx = 0, m_pulse = 0, m_tot = 0, m_rb = 0, m_pts = 0, m_acc = 0, m_lvl = 0;
  bit m_err = 0, m_cmdp = 0;
  localparam int MINV = -8192;

  function automatic logic [8:0] obs();
    return {cap_valid, cap_first, rb_valid, rb_last, pulse_first, pulse_last,
            acq_done, CMD_Update_Disable, cfg_err};
  endfunction

  task automatic check_int(input string tag, input int got, input int want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // one clock: model predicts the registered outputs, DUT is driven, result popped and compared
  task automatic cyc(input bit dv, input int d, input bit ab = 1'b0);
    exp_t e;
    int nxt, idx;
    bit cf, rv, rl, pf, pl;
    logic [8:0] got;
    e = '0;
    nxt = m_st;
    idx = -1;
    {cf, rv, rl} = 3'b000;
    if (m_st == 0 && UR_CMD[0] && !m_cmdp) begin
      m_err = UR_nTotalPoins == 0 || UR_nRangeBins == 0 || UR_nPoints_RB == 0 || UR_nACC_Pulses == 0;
      if (!m_err) begin
        m_tot = int'(UR_nTotalPoins);
        m_rb = int'(UR_nRangeBins);
        m_pts = int'(UR_nPoints_RB);
        m_acc = int'(UR_nACC_Pulses);
        m_lvl = int'($signed(UR_TriggerLevel[13:0]));
        nxt = 1;
      end
    end else if (m_st == 1) begin
      nxt = 2;
      m_prev = MINV;
      m_pulse = 0;
    end else if (m_st == 2 && dv) begin
      if (m_prev < m_lvl && d >= m_lvl) idx = 0;
      else m_prev = d;
    end else if (m_st == 3 && dv) begin
      idx = m_idx;
    end else if (m_st == 4) begin
      nxt = 0;
    end
    pf = (m_st == 2 || m_st == 3) && m_pulse == 0;
    pl = (m_st == 2 || m_st == 3) && m_pulse == m_acc - 1;
    if (idx >= 0) begin
      cf = idx == 0;
      rv = longint'(idx) < longint'(m_rb) * longint'(m_pts);
      rl = rv && (idx % m_pts == m_pts - 1);
      e.ri = 16'(idx / m_pts);
      if (idx == m_tot - 1) begin
        if (m_pulse < m_acc - 1) begin
          m_pulse++;
          m_prev = MINV;
          nxt = 2;
        end else nxt = 4;
      end else begin
        m_idx = idx + 1;
        nxt = 3;
      end
    end
    if (ab && m_st != 0) begin
      nxt = 0;
      idx = -1;
      pf = 0;
      pl = 0;
    end
    e.f = {idx >= 0, cf && idx >= 0, rv && idx >= 0, rl && idx >= 0, pf, pl, nxt == 4, nxt != 0, m_err};
    m_cmdp = UR_CMD[0];
    m_st = nxt;
    sb.push_back(e);
    data_valid = dv;
    trig_data = d[13:0];
    abort_i = ab;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = obs();
    n_chk++;
    assert (got === e.f) else begin
      n_fail++;
      $error("FAIL flags: got %b expected %b (cv cf rv rl pf pl done cud err)", got, e.f);
    end
    if (e.f[8] && e.f[6]) begin
      n_chk++;
      assert (rb_index === e.ri) else begin
        n_fail++;
        $error("FAIL rb_index: got %0d expected %0d", rb_index, e.ri);
      end
    end
    n_cv += int'(cap_valid);
    n_ad += int'(acq_done);
    n_rl += int'(rb_last);
  endtask

  task automatic go(input int t, input int r, input int p, input int a, input int l, input bit ab = 1'b0);
    UR_CMD = '0;
    cyc(0, 0);
    UR_nTotalPoins = 16'(t);
    UR_nRangeBins = 16'(r);
    UR_nPoints_RB = 16'(p);
    UR_nACC_Pulses = 16'(a);
    UR_TriggerLevel = 16'(l);
    UR_CMD = 16'hF0F1;
    cyc(0, 0, ab);
    n_cv = 0;
    n_ad = 0;
    n_rl = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    n_chk++;
    assert ({obs(), rb_index} === 25'b0) else begin
      n_fail++;
      $error("FAIL reset: got %b expected 0", {obs(), rb_index});
    end
    rst = 1'b0;
    // two pulses of 8 samples, 2 bins of 3 points; live fields changed mid-run must not matter
    go(8, 2, 3, 2, 100);
    UR_nTotalPoins = 16'd3;
    for (int k = 0; k < 30; k++) cyc(1, k == 0 ? 0 : k == 1 ? 50 : 50 * k + 50);
    check_int("A cap_valid count", n_cv, 16);
    check_int("A acq_done count", n_ad, 1);
    check_int("A rb_last count", n_rl, 4);
    // zero pulse count rejected, then a good start with one point per bin clears the error
    go(8, 2, 3, 0, 100);
    for (int k = 0; k < 4; k++) cyc(1, 500);
    check_int("B cfg_err set", int'(cfg_err), 1);
    go(4, 4, 1, 1, 100);
    for (int k = 0; k < 10; k++) cyc(1, 500);
    check_int("B cap_valid count", n_cv, 4);
    check_int("B rb_last count", n_rl, 4);
    check_int("B cfg_err cleared", int'(cfg_err), 0);
    // falling and sub-level samples do not trigger; exactly-at-level rising sample does
    go(4, 2, 2, 1, 100);
    for (int k = 0; k < 14; k++) cyc(1, k == 1 ? 50 : k == 2 ? -50 : k == 3 ? 99 : k == 4 ? 100 : 20);
    check_int("C cap_valid count", n_cv, 4);
    check_int("C acq_done count", n_ad, 1);
    // abort in the middle of the second pulse
    go(8, 2, 3, 2, 100);
    for (int k = 0; k < 30; k++) cyc(1, k == 0 ? 0 : k == 1 ? 50 : 50 * k + 50, m_st == 3 && m_pulse == 1 && m_idx == 3);
    check_int("D cap_valid count", n_cv, 11);
    check_int("D acq_done count", n_ad, 0);
    check_int("D freeze released", int'(CMD_Update_Disable), 0);
    // truncated last bin with a gapped sample strobe; abort alongside the start is ignored
    go(5, 2, 3, 1, 100, 1'b1);
    for (int k = 0; k < 30; k++) cyc(k % 2 == 0, k < 6 ? 0 : 500);
    check_int("E cap_valid count", n_cv, 5);
    check_int("E rb_last count", n_rl, 1);
    // crossings inside the window are ignored, then reset lands mid-capture
    go(8, 2, 3, 1, 100);
    for (int k = 0; k < 20 && !(m_st == 3 && m_idx == 5); k++) cyc(1, k % 2 ? 150 : 50);
    check_int("F samples before reset", n_cv, 5);
    rst = 1'b1;
    #1;
    n_chk++;
    assert ({obs(), rb_index} === 25'b0) else begin
      n_fail++;
      $error("FAIL mid-run reset: got %b expected 0", {obs(), rb_index});
    end
    UR_CMD = '0;
    m_st = 0;
    m_err = 0;
    m_cmdp = 0;
    #3;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1, 150);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
